// File: rtl/pll_reconfig_ctrl_pkg.sv
// Shared state encoding, field widths, reset defaults and request type for the PLL reconfiguration controller.
package pll_reconfig_ctrl_pkg;
  localparam int ODIV_W  = 10;
  localparam int DUTY_W  = 10;
  localparam int PHASE_W = 13;

  localparam logic [ODIV_W-1:0]  DEF_ODIV  = 10'd100;
  localparam logic [DUTY_W-1:0]  DEF_DUTY  = 10'd100;
  localparam logic [PHASE_W-1:0] DEF_PHASE = 13'd16;

  typedef enum logic [2:0] {
    S_PWD, S_RST, S_WAIT_LOCK, S_STABLE, S_LOCKED, S_ERR
  } pll_state_e;

  typedef struct packed {
    logic [2:0]         sel;
    logic [ODIV_W-1:0]  odiv;
    logic [DUTY_W-1:0]  duty;
    logic [PHASE_W-1:0] phase;
  } cfg_req_t;

  // Duty is compared against twice the divider in 11 bits so 2*odiv cannot wrap.
  function automatic logic req_ok(input cfg_req_t r, input int num_out);
    return (int'(r.sel) < num_out) && (r.odiv != '0) && (r.duty != '0) &&
           ({1'b0, r.duty} < {r.odiv, 1'b0});
  endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the raw PLL lock plus a consecutive-high qualifier.
module pll_lock_sync #(
  parameter int LOCK_STABLE = 8
) (
  input  logic clk_tb,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic clr,
  output logic lock_s,
  output logic stable
);
  localparam int HW = $clog2(LOCK_STABLE + 1);

  logic          meta;
  logic [HW-1:0] hi_cnt;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      lock_s <= 1'b0;
      hi_cnt <= '0;
    end else begin
      meta   <= pll_lock;
      lock_s <= meta;
      if (clr || !lock_s)                  hi_cnt <= '0;
      else if (hi_cnt != HW'(LOCK_STABLE)) hi_cnt <= hi_cnt + 1'b1;
    end
  end

  // High on the LOCK_STABLE-th consecutive synchronized high cycle.
  assign stable = lock_s && (hi_cnt >= HW'(LOCK_STABLE - 1));
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL power-up / reconfiguration sequencer: PWD -> RST -> WAIT_LOCK -> STABLE -> LOCKED (+ ERR).
// Define PLL_RECONFIG_AUTO_RELOCK_EN to retry one reset sequence on a lock timeout before flagging err.
module pll_reconfig_ctrl
  import pll_reconfig_ctrl_pkg::*;
#(
  parameter int NUM_OUT      = 5,
  parameter int PWD_CYCLES   = 8,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                       clk_tb,
  input  logic                       rst_n,
  input  logic                       pll_lock,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [2:0]                 cfg_sel,
  input  logic [ODIV_W-1:0]          cfg_odiv,
  input  logic [DUTY_W-1:0]          cfg_duty,
  input  logic [PHASE_W-1:0]         cfg_phase,
  output logic                       pll_pwd,
  output logic                       pll_rst,
  output logic                       rstodiv,
  output logic [ODIV_W*NUM_OUT-1:0]  dyn_odiv,
  output logic [DUTY_W*NUM_OUT-1:0]  dyn_duty,
  output logic [PHASE_W*NUM_OUT-1:0] dyn_phase,
  output logic                       locked,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 lock_lost_cnt
);
  localparam int CNT_MAX = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

  pll_state_e                       state;
  logic [CNT_W-1:0]                 cnt;
  logic [TMO_W-1:0]                 tmo_cnt;
  logic [NUM_OUT-1:0][ODIV_W-1:0]   odiv_q;
  logic [NUM_OUT-1:0][DUTY_W-1:0]   duty_q;
  logic [NUM_OUT-1:0][PHASE_W-1:0]  phase_q;
  cfg_req_t                         req;
  logic                             xfer, req_good, lock_s, lock_stable, sync_clr;
`ifdef PLL_RECONFIG_AUTO_RELOCK_EN
  logic                             retried;
`endif

  assign req       = '{sel: cfg_sel, odiv: cfg_odiv, duty: cfg_duty, phase: cfg_phase};
  assign xfer      = cfg_valid && cfg_ready;
  assign req_good  = req_ok(req, NUM_OUT);
  assign sync_clr  = (state != S_WAIT_LOCK) && (state != S_STABLE);
  assign dyn_odiv  = odiv_q;
  assign dyn_duty  = duty_q;
  assign dyn_phase = phase_q;

  pll_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock_sync (
    .clk_tb  (clk_tb),
    .rst_n   (rst_n),
    .pll_lock(pll_lock),
    .clr     (sync_clr),
    .lock_s  (lock_s),
    .stable  (lock_stable)
  );

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_PWD;
      cnt           <= '0;
      tmo_cnt       <= '0;
      pll_pwd       <= 1'b1;
      pll_rst       <= 1'b1;
      rstodiv       <= 1'b1;
      cfg_ready     <= 1'b0;
      locked        <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      lock_lost_cnt <= '0;
      odiv_q        <= {NUM_OUT{DEF_ODIV}};
      duty_q        <= {NUM_OUT{DEF_DUTY}};
      phase_q       <= {NUM_OUT{DEF_PHASE}};
`ifdef PLL_RECONFIG_AUTO_RELOCK_EN
      retried       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (xfer && req_good) begin
        odiv_q[req.sel]  <= req.odiv;
        duty_q[req.sel]  <= req.duty;
        phase_q[req.sel] <= req.phase;
        err       <= 1'b0;
        state     <= S_RST;
        cnt       <= '0;
        pll_rst   <= 1'b1;
        rstodiv   <= 1'b1;
        cfg_ready <= 1'b0;
        locked    <= 1'b0;
`ifdef PLL_RECONFIG_AUTO_RELOCK_EN
        retried   <= 1'b0;
`endif
      end else begin
        // A rejected request is consumed and only flags err; the state machine carries on.
        if (xfer) err <= 1'b1;
        unique case (state)
          S_PWD:
            if (cnt == CNT_W'(PWD_CYCLES - 1)) begin
              state   <= S_RST;
              cnt     <= '0;
              pll_pwd <= 1'b0;
            end else cnt <= cnt + 1'b1;
          S_RST:
            if (cnt == CNT_W'(RST_CYCLES - 1)) begin
              state   <= S_WAIT_LOCK;
              pll_rst <= 1'b0;
              rstodiv <= 1'b0;
              tmo_cnt <= '0;
            end else cnt <= cnt + 1'b1;
          S_WAIT_LOCK:
            if (lock_s) state <= S_STABLE;
            else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
`ifdef PLL_RECONFIG_AUTO_RELOCK_EN
              if (!retried) begin
                retried <= 1'b1;
                state   <= S_RST;
                cnt     <= '0;
                pll_rst <= 1'b1;
                rstodiv <= 1'b1;
              end else begin
                state     <= S_ERR;
                err       <= 1'b1;
                cfg_ready <= 1'b1;
              end
`else
              state     <= S_ERR;
              err       <= 1'b1;
              cfg_ready <= 1'b1;
`endif
            end else tmo_cnt <= tmo_cnt + 1'b1;
          // Falling back to WAIT_LOCK keeps the timeout count running.
          S_STABLE:
            if (!lock_s) state <= S_WAIT_LOCK;
            else if (lock_stable) begin
              state     <= S_LOCKED;
              locked    <= 1'b1;
              done      <= 1'b1;
              cfg_ready <= 1'b1;
`ifdef PLL_RECONFIG_AUTO_RELOCK_EN
              retried   <= 1'b0;
`endif
            end
          S_LOCKED:
            if (!lock_s) begin
              state     <= S_WAIT_LOCK;
              locked    <= 1'b0;
              cfg_ready <= 1'b0;
              tmo_cnt   <= '0;
              if (lock_lost_cnt != 2'd3) lock_lost_cnt <= lock_lost_cnt + 2'd1;
            end
          S_ERR: ;
          default: state <= S_PWD;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl (LOCK_TIMEOUT shortened to 100); honours PLL_RECONFIG_AUTO_RELOCK_EN.
module tb_pll_reconfig_ctrl;
  import pll_reconfig_ctrl_pkg::*;

  localparam int NUM_OUT = 5;
  localparam int RST_CYC = 16;
  localparam int TMO     = 100;
  localparam int LAT     = 10;  // 2 sync flops + 8 stable cycles, from raw lock rise

  logic                 clk_tb = 1'b0, rst_n = 1'b0, pll_lock = 1'b0, cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [2:0]           cfg_sel = '0;
  logic [9:0]           cfg_odiv = '0, cfg_duty = '0;
  logic [12:0]          cfg_phase = '0;
  logic                 pll_pwd, pll_rst, rstodiv, locked, done, err;
  logic [1:0]           lock_lost_cnt;
  logic [10*NUM_OUT-1:0] dyn_odiv, dyn_duty;
  logic [13*NUM_OUT-1:0] dyn_phase;

  int n_chk = 0, n_err = 0;

  typedef struct { string tag; logic [127:0] val; } exp_t;
  exp_t sb[$];

  logic [10*NUM_OUT-1:0] m_odiv  = {NUM_OUT{DEF_ODIV}};
  logic [10*NUM_OUT-1:0] m_duty  = {NUM_OUT{DEF_DUTY}};
  logic [13*NUM_OUT-1:0] m_phase = {NUM_OUT{DEF_PHASE}};

  logic [2:0]  rj_sel [4] = '{3'd2,   3'd5,    3'd0,  3'd3};
  logic [9:0]  rj_odv [4] = '{10'd50, 10'd100, 10'd0, 10'd10};
  logic [9:0]  rj_dty [4] = '{10'd100,10'd100, 10'd1, 10'd20};

  pll_reconfig_ctrl #(.NUM_OUT(NUM_OUT), .LOCK_TIMEOUT(TMO)) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .pll_lock(pll_lock),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_odiv(cfg_odiv), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst), .rstodiv(rstodiv),
    .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty), .dyn_phase(dyn_phase),
    .locked(locked), .done(done), .err(err), .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [127:0] v);
    exp_t e;
    e.tag = tag; e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_chk(input logic [127:0] act);
    exp_t e;
    if (sb.size() == 0) chk("sb_empty", 128'(sb.size()), 128'd1);
    else begin
      e = sb.pop_front();
      chk(e.tag, act, e.val);
    end
  endtask

  task automatic push_dyn();
    sb_push("dyn_odiv", 128'(m_odiv));
    sb_push("dyn_duty", 128'(m_duty));
    sb_push("dyn_phase", 128'(m_phase));
  endtask

  task automatic pop_dyn();
    sb_chk(128'(dyn_odiv));
    sb_chk(128'(dyn_duty));
    sb_chk(128'(dyn_phase));
  endtask

  // Drives one request, waits (bounded) for ready, returns on the negedge after the transfer.
  task automatic send_req(input logic [2:0] sel, input logic [9:0] od, input logic [9:0] du,
                          input logic [12:0] ph, output bit ok);
    int w;
    ok = (int'(sel) < NUM_OUT) && (od != 0) && (du != 0) && ({1'b0, du} < {od, 1'b0});
    if (ok) begin
      m_odiv[int'(sel)*10 +: 10]  = od;
      m_duty[int'(sel)*10 +: 10]  = du;
      m_phase[int'(sel)*13 +: 13] = ph;
      push_dyn();
    end else begin
      sb_push("rej_err", 128'd1);
      sb_push("rej_dyn_odiv", 128'(m_odiv));
      sb_push("rej_dyn_duty", 128'(m_duty));
    end
    cfg_sel = sel; cfg_odiv = od; cfg_duty = du; cfg_phase = ph; cfg_valid = 1'b1;
    w = 0;
    while (cfg_ready !== 1'b1 && w < 200) begin w++; @(negedge clk_tb); end
    if (w >= 200) chk("ready_wait", 128'(w), 128'd0);
    @(negedge clk_tb);
    cfg_valid = 1'b0;
    if (ok) begin
      chk("ready_drop", cfg_ready, 1'b0);
      chk("req_rst", pll_rst, 1'b1);
      chk("req_err_clr", err, 1'b0);
    end
  endtask

  task automatic rst_len(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 200) begin n++; @(negedge clk_tb); end
  endtask

  task automatic wait_locked(output int n, output int early, output int rsts);
    n = 0; early = 0; rsts = 0;
    while (locked !== 1'b1 && n < 300) begin
      if (done === 1'b1) early++;
      if (pll_rst === 1'b1) rsts++;
      n++; @(negedge clk_tb);
    end
  endtask

  // Called while pll_rst is high: models the PLL dropping lock, relocking gap cycles after reset.
  task automatic relock_chk(input string tag, input int gap);
    int n, early, rsts;
    pll_lock = 1'b0;
    chk({tag, "_rstodiv_hi"}, rstodiv, 1'b1);
    rst_len(n);
    chk({tag, "_rst_len"}, 128'(n), 128'(RST_CYC));
    chk({tag, "_rstodiv_lo"}, rstodiv, 1'b0);
    repeat (gap) @(negedge clk_tb);
    pll_lock = 1'b1;
    wait_locked(n, early, rsts);
    chk({tag, "_lock_lat"}, 128'(n), 128'(LAT));
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_early_done"}, 128'(early), 128'd0);
    chk({tag, "_ready"}, cfg_ready, 1'b1);
    pop_dyn();
    @(negedge clk_tb);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, early, rsts, cnt;
    bit ok;

    repeat (3) @(negedge clk_tb);
    chk("rst_pwd", pll_pwd, 1'b1);
    chk("rst_rst", pll_rst, 1'b1);
    chk("rst_rstodiv", rstodiv, 1'b1);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_lost", lock_lost_cnt, 2'd0);
    chk("rst_odiv", 128'(dyn_odiv), 128'(m_odiv));
    chk("rst_phase", 128'(dyn_phase), 128'(m_phase));

    // Power-up
    push_dyn();
    rst_n = 1'b1;
    n = 0;
    while (pll_pwd === 1'b1 && n < 100) begin n++; @(negedge clk_tb); end
    chk("pwd_len", 128'(n), 128'd8);
    relock_chk("pwrup", 40);

    // Reconfigure output 2
    send_req(3'd2, 10'd200, 10'd200, 13'd16, ok);
    relock_chk("cfg2", 5);

    // Rejected requests: no reset pulse, fields untouched, still locked
    for (int i = 0; i < 4; i++) begin
      send_req(rj_sel[i], rj_odv[i], rj_dty[i], 13'd9, ok);
      sb_chk(128'(err));
      sb_chk(128'(dyn_odiv));
      sb_chk(128'(dyn_duty));
      chk("rej_locked", locked, 1'b1);
      cnt = 0;
      repeat (20) begin @(negedge clk_tb); if (pll_rst === 1'b1) cnt++; end
      chk("rej_no_rst", 128'(cnt), 128'd0);
    end

    // Boundary accept (duty = 2*odiv-1, max phase) also clears err
    send_req(3'd4, 10'd10, 10'd19, 13'h1fff, ok);
    relock_chk("cfg4", 5);

    // Lock drops while LOCKED: counter saturates, recovery without reset pulse
    for (int i = 0; i < 4; i++) begin
      sb_push("lost_cnt", (i < 3) ? 128'(i + 1) : 128'd3);
      pll_lock = 1'b0;
      cnt = 0;
      repeat (3) begin @(negedge clk_tb); if (pll_rst === 1'b1) cnt++; end
      chk("drop_locked_low", locked, 1'b0);
      pll_lock = 1'b1;
      wait_locked(n, early, rsts);
      chk("drop_relock_lat", 128'(n), 128'(LAT));
      chk("drop_no_rst", 128'(cnt + rsts), 128'd0);
      sb_chk(128'(lock_lost_cnt));
    end

    // 5-cycle lock glitch during STABLE must not produce done
    send_req(3'd0, 10'd100, 10'd50, 13'd0, ok);
    pll_lock = 1'b0;
    rst_len(n);
    chk("glitch_rst_len", 128'(n), 128'(RST_CYC));
    repeat (3) @(negedge clk_tb);
    pll_lock = 1'b1;
    cnt = 0;
    repeat (5) begin @(negedge clk_tb); if (done === 1'b1) cnt++; end
    pll_lock = 1'b0;
    repeat (4) begin @(negedge clk_tb); if (done === 1'b1) cnt++; end
    chk("glitch_no_done", 128'(cnt), 128'd0);
    chk("glitch_unlocked", locked, 1'b0);
    pll_lock = 1'b1;
    wait_locked(n, early, rsts);
    chk("glitch_lock_lat", 128'(n), 128'(LAT));
    chk("glitch_early_done", 128'(early), 128'd0);
    chk("glitch_done", done, 1'b1);
    pop_dyn();

    // Lock never returns: timeout
    send_req(3'd1, 10'd20, 10'd20, 13'd5, ok);
    pll_lock = 1'b0;
    rst_len(n);
    chk("tmo_rst_len", 128'(n), 128'(RST_CYC));
    n = 0;
    while (err !== 1'b1 && pll_rst !== 1'b1 && n < 300) begin n++; @(negedge clk_tb); end
    chk("tmo_len", 128'(n), 128'(TMO));
`ifdef PLL_RECONFIG_AUTO_RELOCK_EN
    chk("tmo_retry_rst", pll_rst, 1'b1);
    chk("tmo_retry_no_err", err, 1'b0);
    rst_len(n);
    chk("tmo_retry_rst_len", 128'(n), 128'(RST_CYC));
    n = 0;
    while (err !== 1'b1 && pll_rst !== 1'b1 && n < 300) begin n++; @(negedge clk_tb); end
    chk("tmo_len2", 128'(n), 128'(TMO));
`endif
    chk("tmo_err", err, 1'b1);
    chk("tmo_unlocked", locked, 1'b0);
    chk("tmo_ready", cfg_ready, 1'b1);
    pop_dyn();

    // Recovery from ERR by a valid request
    send_req(3'd3, 10'd30, 10'd30, 13'd1, ok);
    relock_chk("recover", 5);
    chk("sb_leftover", 128'(sb.size()), 128'd0);

    // Asynchronous reset mid reset-sequence
    send_req(3'd2, 10'd7, 10'd7, 13'd3, ok);
    pop_dyn();
    repeat (3) @(negedge clk_tb);
    rst_n = 1'b0;
    #1;
    m_odiv = {NUM_OUT{DEF_ODIV}}; m_duty = {NUM_OUT{DEF_DUTY}}; m_phase = {NUM_OUT{DEF_PHASE}};
    chk("arst_pwd", pll_pwd, 1'b1);
    chk("arst_odiv", 128'(dyn_odiv), 128'(m_odiv));
    chk("arst_duty", 128'(dyn_duty), 128'(m_duty));
    chk("arst_phase", 128'(dyn_phase), 128'(m_phase));
    chk("arst_lost", lock_lost_cnt, 2'd0);
    chk("arst_ready", cfg_ready, 1'b0);
    @(negedge clk_tb);
    rst_n = 1'b1;
    n = 0;
    while (pll_pwd === 1'b1 && n < 100) begin n++; @(negedge clk_tb); end
    chk("arst_pwd_len", 128'(n), 128'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequences power-up, reset and dynamic reconfiguration of the Config_HDMI PLL: power-down pulse, reset pulse, wait for lock, lock-stability qualification.
- Accepts per-output divider/duty/phase update requests over a valid/ready handshake and drives the dyn_* configuration buses.
- Sits between the video/system control logic and the PLL instance and reports lock health upstream.

Parameters:
- NUM_OUT, 5, number of PLL outputs (clkout0..clkout4).
- PWD_CYCLES, 8, cycles pll_pwd is held high during power-up.
- RST_CYCLES, 16, cycles pll_rst is held high per (re)lock.
- LOCK_STABLE, 8, consecutive synchronized pll_lock=1 cycles required before declaring locked.
- LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK before error.
- DEF_ODIV / DEF_DUTY / DEF_PHASE, 100 / 100 / 16, reset values of every output's divider, duty and phase.

Ports:
- clk_tb  in  1  controller clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pll_lock  in  1  raw PLL lock; asynchronous, 2-flop synchronized internally.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  controller can accept a request.
- cfg_sel  in  3  output index 0..NUM_OUT-1.
- cfg_odiv  in  10  new output divider.
- cfg_duty  in  10  new duty value.
- cfg_phase  in  13  new phase value.
- pll_pwd  out  1  PLL power-down.
- pll_rst  out  1  PLL reset.
- rstodiv  out  1  output-divider reset, asserted together with pll_rst.
- dyn_odiv  out  10*NUM_OUT  packed dividers; output i at [10i+9:10i].
- dyn_duty  out  10*NUM_OUT  packed duty values, same packing.
- dyn_phase  out  13*NUM_OUT  packed phase values; output i at [13i+12:13i].
- locked  out  1  qualified lock status.
- done  out  1  one-cycle pulse when a sequence reaches LOCKED.
- err  out  1  sticky error: timeout or rejected request.
- lock_lost_cnt  out  2  saturating count of lock drops while LOCKED.

Behaviour:
- Reset values:
  - pll_pwd = 1, pll_rst = 1, rstodiv = 1.
  - dyn_* fields at DEF_*.
  - cfg_ready = 0, locked = 0, done = 0, err = 0, lock_lost_cnt = 0.
- State machine: PWD -> RST -> WAIT_LOCK -> STABLE -> LOCKED; plus ERR.
  - PWD: pll_pwd = 1 for PWD_CYCLES, then go to RST. Entered only out of reset.
  - RST: pll_rst = rstodiv = 1 for RST_CYCLES; pll_pwd = 0. Then go to WAIT_LOCK.
  - WAIT_LOCK: counts cycles. Synced lock = 1 -> STABLE. Count reaches LOCK_TIMEOUT -> ERR and set err.
  - STABLE: counts consecutive synced lock = 1. Any 0 -> back to WAIT_LOCK, timeout counter not cleared. Count reaches LOCK_STABLE -> LOCKED, with locked = 1 and done pulsed in the same cycle.
  - LOCKED: cfg_ready = 1.
  - ERR: cfg_ready = 1, locked = 0.
- Handshake:
  - A transfer occurs on a clk_tb edge with cfg_valid & cfg_ready.
  - On transfer, the fields of output cfg_sel are written and the FSM goes to RST on the next cycle.
  - cfg_ready drops in the cycle after transfer. err is cleared on an accepted request.
- Request rejection: cfg_sel >= NUM_OUT, cfg_odiv == 0, cfg_duty == 0, or cfg_duty >= 2*cfg_odiv (11-bit compare).
  - The request is consumed (ready handshake completes) but no field changes and no reset sequence starts.
  - err is set; the state is unchanged.
- Lock loss in LOCKED (synced lock = 0):
  - locked -> 0 next cycle.
  - lock_lost_cnt increments, saturating at 3.
  - FSM goes to WAIT_LOCK with no reset pulse.
- Lock rise during RST is ignored.
- A cfg_valid held while cfg_ready = 0 waits; it is not dropped.
- Asynchronous reset mid-sequence returns everything to reset values and restarts from PWD.

Optional Feature:
- Macro: PLL_RECONFIG_AUTO_RELOCK_EN.
- When defined: a WAIT_LOCK timeout does not go to ERR on the first occurrence. The FSM returns to RST for one retry, and goes to ERR only on a second consecutive timeout.
- When not defined: the first timeout goes straight to ERR.

Decomposition:
- Shared package holds:
  - State enum encoding.
  - Field widths: ODIV_W = 10, DUTY_W = 10, PHASE_W = 13.
  - DEF_* constants.
- One sub-module: pll_lock_sync, a 2-flop synchronizer plus consecutive-high counter that outputs the stable-lock qualifier.

Test Plan:
- Power-up, lock asserted 40 cycles after pll_rst falls -> pll_pwd high 8 cycles; pll_rst high 16 cycles; locked = 1 and done pulse exactly 8 cycles after synced lock; dyn_odiv all fields = 100.
- Request sel = 2, odiv = 200, duty = 200, phase = 16 in LOCKED -> dyn_odiv[29:20] = 200, other fields unchanged; 16-cycle pll_rst; done after relock.
- Request odiv = 50, duty = 100 (duty >= 2*odiv) -> err = 1, no pll_rst pulse, dyn unchanged, locked stays 1.
- pll_lock never asserts, LOCK_TIMEOUT = 100 -> err = 1 after 100 WAIT_LOCK cycles without macro; with macro, one extra 16-cycle pll_rst first.
- Drop pll_lock 4 times for 3 cycles each in LOCKED -> lock_lost_cnt = 3 (saturated); locked recovers each time without pll_rst.
- Glitch lock high for 5 cycles in STABLE -> no done; done only after 8 consecutive high cycles.
